// File: rtl/mdu_booth_seq_if.sv
// -----------------------------------------------------------------------------
// mdu_booth_seq_if
//
// Purpose: control/status bundle between the E-stage pipeline logic and the
// multiply/divide sequencer. The pipeline side uses the master modport and the
// sequencer uses the slave modport.
//
// Parameter:
//   CNT_W      width of STEP_IDX
//
// Signals (master -> slave):
//   START      operation request
//   OP[1:0]    00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   DIVZERO    divisor is zero (sampled at accept)
//   KILL       synchronous abort from pipeline flush
//   EARLY_OK   remaining multiplier digits are all sign bits
// Signals (slave -> master):
//   BUSY, MULT_STEP, DIV_STEP, FIXUP, STEP_IDX, SIGNED_OP,
//   MULTUSCYC, MULTSHCYC, DIV2HI, HI_WE, DIV_ERR, DONE
// -----------------------------------------------------------------------------
interface mdu_booth_seq_if #(
    parameter int CNT_W = 6
) ();
    logic             START;
    logic [1:0]       OP;
    logic             DIVZERO;
    logic             KILL;
    logic             EARLY_OK;

    logic             BUSY;
    logic             MULT_STEP;
    logic             DIV_STEP;
    logic             FIXUP;
    logic [CNT_W-1:0] STEP_IDX;
    logic             SIGNED_OP;
    logic             MULTUSCYC;
    logic             MULTSHCYC;
    logic             DIV2HI;
    logic             HI_WE;
    logic             DIV_ERR;
    logic             DONE;

    modport master (
        output START, OP, DIVZERO, KILL, EARLY_OK,
        input  BUSY, MULT_STEP, DIV_STEP, FIXUP, STEP_IDX, SIGNED_OP,
               MULTUSCYC, MULTSHCYC, DIV2HI, HI_WE, DIV_ERR, DONE
    );

    modport slave (
        input  START, OP, DIVZERO, KILL, EARLY_OK,
        output BUSY, MULT_STEP, DIV_STEP, FIXUP, STEP_IDX, SIGNED_OP,
               MULTUSCYC, MULTSHCYC, DIV2HI, HI_WE, DIV_ERR, DONE
    );
endinterface

// File: rtl/mdu_booth_seq.sv
// -----------------------------------------------------------------------------
// mdu_booth_seq
//
// Purpose: sequencer for the multi-cycle multiply/divide unit. Accepts one
// operation per START, steps the radix-4 Booth multiplier datapath (one digit
// per cycle) or the restoring divider (one bit per cycle), strobes the signed
// divide fixup, and produces the one-cycle HI/LO writeback with its one-hot
// result-mux selects and the BUSY/DONE handshake to the E stage.
//
// Parameters:
//   WIDTH      operand width, even, 8..64
//   CNT_W      STEP_IDX width, 2**CNT_W > WIDTH
//
// Ports:
//   CLK        clock, rising edge
//   RESET      asynchronous active-high reset
//   mdu        mdu_booth_seq_if.slave bundle (START/OP/DIVZERO/KILL/EARLY_OK in,
//              BUSY/step strobes/STEP_IDX/SIGNED_OP/writeback selects/
//              HI_WE/DIV_ERR/DONE out)
//
// Optional feature (compile-time macro MDU_EARLY_OUT_EN):
//   When defined, a signed multiply finishes early once EARLY_OK reports that
//   the remaining multiplier digits are pure sign extension (earliest at
//   STEP_IDX=1). When undefined, EARLY_OK is ignored.
// -----------------------------------------------------------------------------
module mdu_booth_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic              CLK,
    input  logic              RESET,
    mdu_booth_seq_if.slave    mdu
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MUL   = 3'd1;
    localparam logic [2:0] S_DIV   = 3'd2;
    localparam logic [2:0] S_FIXUP = 3'd3;
    localparam logic [2:0] S_WB    = 3'd4;

    // Index of the final step of each operation. Unsigned multiply needs one
    // extra Booth digit to absorb the zero-extended top bit of the multiplier.
    localparam logic [CNT_W-1:0] LAST_MULT  = CNT_W'(WIDTH/2 - 1);
    localparam logic [CNT_W-1:0] LAST_MULTU = CNT_W'(WIDTH/2);
    localparam logic [CNT_W-1:0] LAST_DIV   = CNT_W'(WIDTH - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] step_idx_q, step_idx_d;
    logic             signed_op_q, signed_op_d;
    logic             is_div_q, is_div_d;
    logic             div_err_q, div_err_d;

    logic             in_mul, in_div, in_fix, in_wb;
    logic             accept;
    logic             mul_last;
    logic             early_last;

    assign in_mul = (state_q == S_MUL);
    assign in_div = (state_q == S_DIV);
    assign in_fix = (state_q == S_FIXUP);
    assign in_wb  = (state_q == S_WB);

    // New work is taken in IDLE and in WB (back-to-back without a bubble);
    // a flush in the same cycle wins over the request.
    assign accept = mdu.START & ~mdu.KILL & (state_q == S_IDLE || in_wb);

`ifdef MDU_EARLY_OUT_EN
    assign early_last = signed_op_q & mdu.EARLY_OK & (step_idx_q != '0);
`else
    logic unused_early_ok;
    assign unused_early_ok = mdu.EARLY_OK;
    assign early_last      = 1'b0;
`endif

    assign mul_last = early_last |
                      (step_idx_q == (signed_op_q ? LAST_MULT : LAST_MULTU));

    always_comb begin
        state_d     = state_q;
        step_idx_d  = step_idx_q;
        signed_op_d = signed_op_q;
        is_div_d    = is_div_q;
        div_err_d   = div_err_q;

        case (state_q)
            S_IDLE, S_WB: begin
                if (accept) begin
                    signed_op_d = mdu.OP[0];
                    is_div_d    = mdu.OP[1];
                    step_idx_d  = '0;
                    div_err_d   = mdu.OP[1] & mdu.DIVZERO;
                    if (!mdu.OP[1]) begin
                        state_d = S_MUL;
                    end else if (mdu.DIVZERO) begin
                        // Nothing to compute: report the error straight away.
                        state_d = S_WB;
                    end else begin
                        state_d = S_DIV;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                // STEP_IDX stays at the last digit so it never runs past
                // the operand during WB.
                if (mul_last) begin
                    state_d = S_WB;
                end else begin
                    step_idx_d = step_idx_q + 1'b1;
                end
            end
            S_DIV: begin
                if (step_idx_q == LAST_DIV) begin
                    state_d = signed_op_q ? S_FIXUP : S_WB;
                end else begin
                    step_idx_d = step_idx_q + 1'b1;
                end
            end
            S_FIXUP: begin
                state_d = S_WB;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush abandons whatever is in flight. The WB outputs of the current
        // cycle are Moore outputs and are therefore unaffected.
        if (mdu.KILL) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            step_idx_q  <= '0;
            signed_op_q <= 1'b0;
            is_div_q    <= 1'b0;
            div_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_idx_q  <= step_idx_d;
            signed_op_q <= signed_op_d;
            is_div_q    <= is_div_d;
            div_err_q   <= div_err_d;
        end
    end

    assign mdu.BUSY      = in_mul | in_div | in_fix;
    assign mdu.MULT_STEP = in_mul;
    assign mdu.DIV_STEP  = in_div;
    assign mdu.FIXUP     = in_fix;
    assign mdu.STEP_IDX  = step_idx_q;
    assign mdu.SIGNED_OP = signed_op_q;

    // Writeback selects are one-hot during WB and all low otherwise.
    assign mdu.MULTUSCYC = in_wb & ~is_div_q & ~signed_op_q;
    assign mdu.MULTSHCYC = in_wb & ~is_div_q &  signed_op_q;
    assign mdu.DIV2HI    = in_wb &  is_div_q;
    assign mdu.HI_WE     = in_wb;
    assign mdu.DIV_ERR   = in_wb & div_err_q;
    assign mdu.DONE      = in_wb;

endmodule
